// File: rtl/exp_sub_pkg.sv
// Shared types and widths for the exponent-subtractor scheduler.
package exp_sub_pkg;

  localparam int unsigned EXP_W = 8;

  typedef enum logic [1:0] {IDLE, SUB_AB, SUB_BA, HOLD} exp_sub_state_e;

  // Result payload returned to the alignment logic
  typedef struct packed {
    logic             swap;
    logic [EXP_W-1:0] diff;
  } exp_sub_rsp_t;

endpackage

// File: rtl/SUB_8bit.sv
// 8-bit unsigned subtractor with borrow-in; o_borrow is set when a < b + carry.
module SUB_8bit (
  input  logic [7:0] i_data_a,
  input  logic [7:0] i_data_b,
  input  logic       i_carry,
  output logic [7:0] o_sub,
  output logic       o_borrow
);

  logic [8:0] full;

  assign full     = {1'b0, i_data_a} - {1'b0, i_data_b} - 9'(i_carry);
  assign o_sub    = full[7:0];
  assign o_borrow = full[8];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer holds the last granted index and moves on i_accept.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] cand;
  logic            found;

  // Search starts one past the last winner and wraps
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(last_q) + i) % NUM_REQ);
      if (!found && i_en && i_req[cand]) begin
        found          = 1'b1;
        o_grant[cand]  = 1'b1;
        o_grant_idx    = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= ID_W'(NUM_REQ - 1);
    end else if (i_accept) begin
      last_q <= o_grant_idx;
    end
  end

endmodule

// File: rtl/exp_sub_sched.sv
// Shares one 8-bit exponent subtractor among NUM_REQ requesters, returning |A-B| and a swap flag.
module exp_sub_sched
  import exp_sub_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0][EXP_W-1:0] i_req_exp_a,
  input  logic [NUM_REQ-1:0][EXP_W-1:0] i_req_exp_b,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [EXP_W-1:0]              o_rsp_diff,
  output logic                          o_rsp_swap,
  input  logic                          i_rsp_ready,
  output logic                          o_busy
);

  exp_sub_state_e state_q, state_d;

  logic [EXP_W-1:0] op_a, op_b;
  logic [ID_W-1:0]  op_id;
  exp_sub_rsp_t     rsp_q, rsp_d;
  logic             load_rsp;

  logic             arb_en;
  logic             hs;
  logic [ID_W-1:0]  grant_idx;

  logic [EXP_W-1:0] sub_a, sub_b, sub_res;
  logic             sub_borrow;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req_valid),
    .i_en        (arb_en),
    .i_accept    (hs),
    .o_grant     (o_req_ready),
    .o_grant_idx (grant_idx)
  );

  SUB_8bit u_sub (
    .i_data_a (sub_a),
    .i_data_b (sub_b),
    .i_carry  (1'b0),
    .o_sub    (sub_res),
    .o_borrow (sub_borrow)
  );

  // Grants only while idle and out of reset, so reset always shows a quiet request side
  assign arb_en = (state_q == IDLE) && !i_rst;
  assign hs     = |(i_req_valid & o_req_ready);

  always_comb begin
    state_d  = state_q;
    sub_a    = op_a;
    sub_b    = op_b;
    load_rsp = 1'b0;
    rsp_d    = rsp_q;
    case (state_q)
      IDLE: begin
        if (hs) state_d = SUB_AB;
      end
      SUB_AB: begin
        if (!sub_borrow) begin
          load_rsp   = 1'b1;
          rsp_d.diff = sub_res;
          rsp_d.swap = 1'b0;
          state_d    = HOLD;
        end else begin
          state_d = SUB_BA;
        end
      end
      SUB_BA: begin
        // Second pass with operands swapped; cannot borrow since B > A
        sub_a      = op_b;
        sub_b      = op_a;
        load_rsp   = 1'b1;
        rsp_d.diff = sub_res;
        rsp_d.swap = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      op_id   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_a  <= i_req_exp_a[grant_idx];
        op_b  <= i_req_exp_b[grant_idx];
        op_id <= grant_idx;
      end
      if (load_rsp) rsp_q <= rsp_d;
    end
  end

  assign o_rsp_valid = (state_q == HOLD);
  assign o_rsp_id    = op_id;
  assign o_rsp_diff  = rsp_q.diff;
  assign o_rsp_swap  = rsp_q.swap;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_exp_sub_sched.sv
// Directed bench for exp_sub_sched: latency, two-pass results, round-robin order, backpressure, reset.
module tb_exp_sub_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic [NUM_REQ-1:0]      i_req_valid;
  logic [NUM_REQ-1:0][7:0] i_req_exp_a;
  logic [NUM_REQ-1:0][7:0] i_req_exp_b;
  logic [NUM_REQ-1:0]      o_req_ready;
  logic                    o_rsp_valid;
  logic [ID_W-1:0]         o_rsp_id;
  logic [7:0]              o_rsp_diff;
  logic                    o_rsp_swap;
  logic                    i_rsp_ready;
  logic                    o_busy;

  int n_cmp = 0;
  int n_err = 0;

  exp_sub_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_exp_a (i_req_exp_a),
    .i_req_exp_b (i_req_exp_b),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_diff  (o_rsp_diff),
    .o_rsp_swap  (o_rsp_swap),
    .i_rsp_ready (i_rsp_ready),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_busy"},  32'(o_busy),      32'd0);
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] diff,
                         input logic swap);
    chk({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(o_rsp_id),    32'(id));
    chk({tag, "_diff"},  32'(o_rsp_diff),  32'(diff));
    chk({tag, "_swap"},  32'(o_rsp_swap),  32'(swap));
    chk({tag, "_rdy"},   32'(o_req_ready), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_order [5];
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_req_exp_a = '0;
    i_req_exp_b = '0;
    i_rsp_ready = 1'b1;
    repeat (2) @(negedge i_clk);

    // Reset values
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_id",    32'(o_rsp_id),    32'd0);
    chk("rst_diff",  32'(o_rsp_diff),  32'd0);
    chk("rst_swap",  32'(o_rsp_swap),  32'd0);
    chk("rst_busy",  32'(o_busy),      32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Single request, A>=B: requester 2, 0x85-0x80
    i_req_valid[2] = 1'b1;
    i_req_exp_a[2] = 8'h85;
    i_req_exp_b[2] = 8'h80;
    #1 chk("t1_grant", 32'(o_req_ready), 32'b0100);
    @(negedge i_clk);
    i_req_valid[2] = 1'b0;
    #1 chk("t1_ab_busy", 32'(o_busy), 32'd1);
    chk("t1_ab_valid", 32'(o_rsp_valid), 32'd0);
    chk("t1_ab_rdy",   32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    chk_rsp("t1", 2'd2, 8'h05, 1'b0);
    chk("t1_hold_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    chk_idle("t1_done");

    // A<B two-pass: requester 1, 0x00 vs 0xFF
    i_req_valid[1] = 1'b1;
    i_req_exp_a[1] = 8'h00;
    i_req_exp_b[1] = 8'hFF;
    #1 chk("t2_grant", 32'(o_req_ready), 32'b0010);
    @(negedge i_clk);
    i_req_valid[1] = 1'b0;
    @(negedge i_clk);
    chk("t2_ba_valid", 32'(o_rsp_valid), 32'd0);
    chk("t2_ba_busy",  32'(o_busy),      32'd1);
    @(negedge i_clk);
    chk_rsp("t2", 2'd1, 8'hFF, 1'b1);
    @(negedge i_clk);
    chk_idle("t2_done");

    // Equal exponents: requester 3, single pass
    i_req_valid[3] = 1'b1;
    i_req_exp_a[3] = 8'h7F;
    i_req_exp_b[3] = 8'h7F;
    #1 chk("t3_grant", 32'(o_req_ready), 32'b1000);
    @(negedge i_clk);
    i_req_valid[3] = 1'b0;
    @(negedge i_clk);
    chk_rsp("t3", 2'd3, 8'h00, 1'b0);
    @(negedge i_clk);
    chk_idle("t3_done");

    // All four requesting; requester 0 re-requests after its first grant
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    exp_order[4] = 4'b0001;
    for (int i = 0; i < NUM_REQ; i++) begin
      i_req_exp_a[i] = 8'h40 + 8'(i);
      i_req_exp_b[i] = 8'h40;
    end
    i_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t4_grant%0d", k), 32'(o_req_ready), 32'(exp_order[k]));
      @(negedge i_clk);
      if (k != 0) i_req_valid = i_req_valid & ~exp_order[k];
      @(negedge i_clk);
      chk_rsp($sformatf("t4_rsp%0d", k), 2'(k % 4), 8'(k % 4), 1'b0);
      @(negedge i_clk);
    end
    chk("t4_all_done", 32'(i_req_valid), 32'd0);
    chk_idle("t4_done");

    // Backpressure: requester 1 served, requester 2 waits behind it
    i_rsp_ready    = 1'b0;
    i_req_exp_a[1] = 8'h10;
    i_req_exp_b[1] = 8'h03;
    i_req_exp_a[2] = 8'h20;
    i_req_exp_b[2] = 8'h21;
    i_req_valid    = 4'b0110;
    #1 chk("t5_grant", 32'(o_req_ready), 32'b0010);
    @(negedge i_clk);
    i_req_valid[1] = 1'b0;
    @(negedge i_clk);
    for (int c = 0; c < 10; c++) begin
      chk_rsp($sformatf("t5_hold%0d", c), 2'd1, 8'h0D, 1'b0);
      @(negedge i_clk);
    end
    i_rsp_ready = 1'b1;
    #1 chk("t5_release_rdy", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    chk_idle("t5_idle");
    #1 chk("t5_next_grant", 32'(o_req_ready), 32'b0100);

    // Requester 2 goes two-pass; reset lands while in SUB_BA
    @(negedge i_clk);
    i_req_valid[2] = 1'b0;
    @(negedge i_clk);
    chk("t6_in_ba_busy", 32'(o_busy), 32'd1);
    i_rst          = 1'b1;
    i_req_exp_a[0] = 8'h09;
    i_req_exp_b[0] = 8'h09;
    i_req_exp_a[3] = 8'h33;
    i_req_exp_b[3] = 8'h11;
    i_req_valid    = 4'b1001;
    @(negedge i_clk);
    chk("t6_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("t6_rst_id",    32'(o_rsp_id),    32'd0);
    chk("t6_rst_diff",  32'(o_rsp_diff),  32'd0);
    chk("t6_rst_swap",  32'(o_rsp_swap),  32'd0);
    chk("t6_rst_busy",  32'(o_busy),      32'd0);
    chk("t6_rst_ready", 32'(o_req_ready), 32'd0);
    i_rst = 1'b0;
    #1 chk("t6_grant", 32'(o_req_ready), 32'b0001);
    @(negedge i_clk);
    i_req_valid[0] = 1'b0;
    @(negedge i_clk);
    chk_rsp("t6", 2'd0, 8'h00, 1'b0);
    @(negedge i_clk);
    chk_idle("t6_done");
    #1 chk("t6_grant3", 32'(o_req_ready), 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
